fan_ctrl: RTL and testbench

- Fan controller FSM fed directly by the 5-bit active-high, one-cycle key pulse vector from the key debouncer.
- Interprets pulses as power, speed-up, speed-down, mode and timer commands.
- Maintains power/speed/mode/off-timer state and drives a PWM motor enable plus status outputs for the display stage.
- Runs on the 1 kHz system clock.

---
 rtl/fan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_fan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fan_ctrl.sv
// Fan controller: power/speed/mode/off-timer state machine driven by one-cycle key pulses,
// with mode-shaped effective speed and a frame-based PWM motor enable.
module fan_ctrl #(
    parameter int unsigned PWM_PERIOD = 12,
    parameter int unsigned UNIT_CYC   = 60000,
    parameter int unsigned TIMER_MAX  = 8,
    parameter int unsigned NAT_CYC    = 3000,
    parameter int unsigned SLEEP_CYC  = 300000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key_pulse,
    output logic       power_on,
    output logic [1:0] speed,
    output logic [1:0] eff_speed,
    output logic [1:0] mode,
    output logic [3:0] timer_left,
    output logic       motor_pwm
);

    localparam logic ST_OFF = 1'b0;
    localparam logic ST_ON  = 1'b1;

    localparam int unsigned FW = $clog2(PWM_PERIOD + 1);
    localparam int unsigned UW = $clog2(UNIT_CYC + 1);
    localparam int unsigned NW = $clog2(NAT_CYC + 1);
    localparam int unsigned SW = $clog2(SLEEP_CYC + 1);
    localparam logic [FW-1:0] PWM_STEP = FW'(PWM_PERIOD / 3);

    logic          state_q, state_d;
    logic [1:0]    spd_q, spd_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    timer_q, timer_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [NW-1:0] nat_q, nat_d;
    logic          phase_q, phase_d;
    logic [SW-1:0] sleep_q, sleep_d;
    logic [1:0]    slp_eff_q, slp_eff_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          pwm_q, pwm_d;

    logic          key_pwr, key_up, key_dn, key_mode, key_tmr;
    logic          spd_key, tick_unit;
    logic [3:0]    t_dec;
    logic [1:0]    eff;
    logic [FW-1:0] thr;

    assign key_pwr  = key_pulse[0];
    assign key_up   = key_pulse[1];
    assign key_dn   = key_pulse[2];
    assign key_mode = key_pulse[3];
    assign key_tmr  = key_pulse[4];
    assign spd_key  = key_up ^ key_dn;
    assign tick_unit = (timer_q != 4'd0) && (unit_q == UW'(UNIT_CYC - 1));
    assign t_dec     = timer_q - {3'b000, tick_unit};

    always_comb begin
        state_d   = state_q;
        spd_d     = spd_q;
        mode_d    = mode_q;
        timer_d   = timer_q;
        unit_d    = unit_q;
        nat_d     = nat_q;
        phase_d   = phase_q;
        sleep_d   = sleep_q;
        slp_eff_d = slp_eff_q;
        frame_d   = frame_q;
        if (state_q == ST_OFF) begin
            if (key_pwr) begin
                state_d = ST_ON;
                spd_d   = 2'd1;
            end
        end else if (key_pwr) begin
            state_d = ST_OFF;
        end else begin
            if (key_up && !key_dn && spd_q != 2'd3) begin
                spd_d = spd_q + 2'd1;
            end else if (key_dn && !key_up && spd_q != 2'd1) begin
                spd_d = spd_q - 2'd1;
            end
            if (key_mode) begin
                mode_d = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
            end
            // Expiry and an add in the same cycle net out; the add wins at 1 -> 0 -> 1.
            if (key_tmr) begin
                timer_d = (t_dec == 4'(TIMER_MAX)) ? 4'd0 : t_dec + 4'd1;
            end else begin
                timer_d = t_dec;
            end
            if (timer_d == 4'd0 || timer_q == 4'd0 || tick_unit) begin
                unit_d = '0;
            end else begin
                unit_d = unit_q + UW'(1);
            end
            if (tick_unit && timer_d == 4'd0) begin
                state_d = ST_OFF;
            end
            if (key_mode) begin
                nat_d     = '0;
                phase_d   = 1'b0;
                sleep_d   = '0;
                slp_eff_d = spd_d;
            end else if (mode_q == 2'd1) begin
                if (nat_q == NW'(NAT_CYC - 1)) begin
                    nat_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    nat_d = nat_q + NW'(1);
                end
            end else if (mode_q == 2'd2) begin
                if (spd_key) begin
                    sleep_d   = '0;
                    slp_eff_d = spd_d;
                end else if (sleep_q == SW'(SLEEP_CYC - 1)) begin
                    sleep_d = '0;
                    if (slp_eff_q > 2'd1) slp_eff_d = slp_eff_q - 2'd1;
                end else begin
                    sleep_d = sleep_q + SW'(1);
                end
            end
            frame_d = (frame_q == FW'(PWM_PERIOD - 1)) ? '0 : frame_q + FW'(1);
        end
        if (state_d == ST_OFF) begin
            timer_d   = 4'd0;
            mode_d    = 2'd0;
            unit_d    = '0;
            nat_d     = '0;
            phase_d   = 1'b0;
            sleep_d   = '0;
            slp_eff_d = 2'd0;
            frame_d   = '0;
        end
    end

    always_comb begin
        eff = 2'd0;
        if (state_q == ST_ON) begin
            case (mode_q)
                2'd1:    eff = phase_q ? spd_q - 2'd1 : spd_q;
                2'd2:    eff = slp_eff_q;
                default: eff = spd_q;
            endcase
        end
    end

    always_comb begin
        case (eff)
            2'd1:    thr = PWM_STEP;
            2'd2:    thr = PWM_STEP + PWM_STEP;
            2'd3:    thr = FW'(PWM_PERIOD);
            default: thr = '0;
        endcase
    end

    // Gated by next power state so the output drops on the same edge as power-off.
    assign pwm_d = (state_d == ST_ON) && (frame_q < thr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            spd_q     <= 2'd1;
            mode_q    <= 2'd0;
            timer_q   <= 4'd0;
            unit_q    <= '0;
            nat_q     <= '0;
            phase_q   <= 1'b0;
            sleep_q   <= '0;
            slp_eff_q <= 2'd0;
            frame_q   <= '0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            spd_q     <= spd_d;
            mode_q    <= mode_d;
            timer_q   <= timer_d;
            unit_q    <= unit_d;
            nat_q     <= nat_d;
            phase_q   <= phase_d;
            sleep_q   <= sleep_d;
            slp_eff_q <= slp_eff_d;
            frame_q   <= frame_d;
            pwm_q     <= pwm_d;
        end
    end

    assign power_on   = state_q;
    assign speed      = (state_q == ST_ON) ? spd_q : 2'd0;
    assign eff_speed  = eff;
    assign mode       = mode_q;
    assign timer_left = timer_q;
    assign motor_pwm  = pwm_q;

endmodule

// File: tb/tb_fan_ctrl.sv
// Directed bench for fan_ctrl with shortened timing parameters; outputs sampled on negedge.
module tb_fan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] key_pulse;
    logic       power_on;
    logic [1:0] speed;
    logic [1:0] eff_speed;
    logic [1:0] mode;
    logic [3:0] timer_left;
    logic       motor_pwm;

    int checks = 0;
    int errors = 0;

    fan_ctrl #(
        .PWM_PERIOD(12),
        .UNIT_CYC  (20),
        .TIMER_MAX (4),
        .NAT_CYC   (6),
        .SLEEP_CYC (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_pulse (key_pulse),
        .power_on  (power_on),
        .speed     (speed),
        .eff_speed (eff_speed),
        .mode      (mode),
        .timer_left(timer_left),
        .motor_pwm (motor_pwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_pwr"}, power_on, 0);
        chk({tag, "_spd"}, speed, 0);
        chk({tag, "_eff"}, eff_speed, 0);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_tmr"}, timer_left, 0);
        chk({tag, "_pwm"}, motor_pwm, 0);
    endtask

    // Called at a negedge; key is sampled on the next posedge, returns at the following negedge.
    task automatic press(input logic [4:0] k);
        key_pulse = k;
        @(negedge clk);
        key_pulse = 5'd0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        key_pulse = 5'd0;
        step(2);
        chk_off("reset");
        rst_n = 1'b1;

        // 1: power on, 4/12 duty, power off
        press(5'b00001);
        chk("on_pwr", power_on, 1);
        chk("on_spd", speed, 1);
        chk("on_mode", mode, 0);
        chk("on_eff", eff_speed, 1);
        chk("on_pwm_lag", motor_pwm, 0);
        step(1);
        chk("pwm_first", motor_pwm, 1);
        cnt = 1;
        for (int i = 0; i < 11; i++) begin
            step(1);
            if (motor_pwm) cnt++;
        end
        chk("pwm_duty1", cnt, 4);
        press(5'b00001);
        chk_off("off1");

        // 2: speed up/down saturation
        press(5'b00001);
        press(5'b00010); chk("up1", speed, 2);
        press(5'b00010); chk("up2", speed, 3);
        press(5'b00010); chk("up3", speed, 3);
        press(5'b00010); chk("up4", speed, 3);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (motor_pwm) cnt++;
        end
        chk("pwm_duty3", cnt, 12);
        press(5'b00100); chk("dn1", speed, 2);
        press(5'b00110); chk("updn2", speed, 2);
        press(5'b00100); chk("dn2", speed, 1);
        press(5'b00100); chk("dn3", speed, 1);
        press(5'b00110); chk("updn1", speed, 1);
        press(5'b00011); chk("pwr_wins", power_on, 0);
        press(5'b00010);
        chk("off_up_spd", speed, 0);
        chk("off_up_pwr", power_on, 0);

        // 3: natural mode at speed 2 then speed 1
        press(5'b00001);
        press(5'b00010);
        press(5'b01000);
        chk("nat_mode", mode, 1);
        chk("nat2_k0", eff_speed, 2);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk($sformatf("nat2_k%0d", k), eff_speed, (k < 6) ? 2 : (k < 12) ? 1 : 2);
        end
        press(5'b00100);
        press(5'b01000); chk("mode_sleep", mode, 2);
        press(5'b01000); chk("mode_norm", mode, 0);
        press(5'b01000); chk("mode_nat", mode, 1);
        chk("nat1_k0", eff_speed, 1);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk($sformatf("nat1_k%0d", k), eff_speed, (k < 6) ? 1 : (k < 12) ? 0 : 1);
            if (k >= 7) chk($sformatf("nat1_pwm_k%0d", k), motor_pwm, 0);
        end

        // 4: sleep mode ramp-down and reload on speed key
        press(5'b00010);
        press(5'b00010);
        press(5'b01000);
        chk("slp_mode", mode, 2);
        chk("slp_k0", eff_speed, 3);
        for (int k = 1; k <= 24; k++) begin
            step(1);
            if (k == 9 || k == 10 || k == 19 || k == 20 || k == 24)
                chk($sformatf("slp_k%0d", k), eff_speed, (k < 10) ? 3 : (k < 20) ? 2 : 1);
        end
        press(5'b00010);
        chk("slp_reload", eff_speed, 3);
        chk("slp_reload_spd", speed, 3);
        step(9);  chk("slp_restart9", eff_speed, 3);
        step(1);  chk("slp_restart10", eff_speed, 2);

        // 5: off-timer countdown and wrap
        press(5'b00001);
        press(5'b00001);
        press(5'b10000); chk("tmr_1", timer_left, 1);
        press(5'b10000); chk("tmr_2", timer_left, 2);
        step(18); chk("tmr_t19", timer_left, 2);
        step(1);  chk("tmr_t20", timer_left, 1);
        step(19);
        chk("tmr_t39_tmr", timer_left, 1);
        chk("tmr_t39_pwr", power_on, 1);
        step(1);
        chk_off("tmr_expire");
        press(5'b00001);
        for (int i = 1; i <= 5; i++) begin
            press(5'b10000);
            chk($sformatf("wrap_%0d", i), timer_left, i % 5);
        end
        step(25);
        chk("wrap_hold_tmr", timer_left, 0);
        chk("wrap_hold_pwr", power_on, 1);

        // 6: expiry coincident with add, with power key, and reset mid-countdown
        press(5'b10000);
        step(19);
        press(5'b10000);
        chk("exp_add_tmr", timer_left, 1);
        chk("exp_add_pwr", power_on, 1);
        step(19);
        press(5'b00001);
        chk("exp_pwr_pwr", power_on, 0);
        chk("exp_pwr_tmr", timer_left, 0);
        press(5'b00001);
        press(5'b00010);
        press(5'b11000);
        chk("multi_mode", mode, 1);
        chk("multi_tmr", timer_left, 1);
        step(5);
        rst_n = 1'b0;
        step(1);
        chk_off("mid_rst");
        rst_n = 1'b1;
        step(3);
        chk_off("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
